// File: rtl/siso_xfer_ctrl.sv
// siso_xfer_ctrl: serialises one word at a time through an external SISO shift register and reassembles it.
// Define SISO_CHECK_EN to add the err port and the transmitted/received word compare.
module siso_xfer_ctrl #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             sr_clear,
    output logic             sr_si,
    input  logic             sr_so
`ifdef SISO_CHECK_EN
    ,
    output logic             err
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [2:0] CLR = 3'd0, IDLE = 3'd1, SEND = 3'd2, WAIT = 3'd3, RECV = 3'd4, DONE = 3'd5;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(DEPTH - WIDTH - 1);

    logic [2:0]       state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    tx_idx;
    logic [WIDTH-1:0] tx_reg;
    logic [WIDTH-1:0] rx_reg;
    logic [WIDTH-1:0] rx_nxt;

    always_comb begin
        tx_idx = MSB_FIRST ? LAST_BIT - cnt : cnt;
        rx_nxt = MSB_FIRST ? (rx_reg << 1) | WIDTH'(sr_so)
                           : (rx_reg >> 1) | (WIDTH'(sr_so) << (WIDTH - 1));
    end

    assign in_ready = state == IDLE;
    assign busy     = state != IDLE;
    assign sr_clear = state == CLR;
    assign sr_si    = state == SEND && |(tx_reg & (WIDTH'(1) << tx_idx));

    // cnt only runs in the timed states and restarts from zero on every entry
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state     <= CLR;
            cnt       <= '0;
            tx_reg    <= '0;
            rx_reg    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                CLR: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                IDLE: begin
                    cnt <= '0;
                    if (in_valid) begin
                        state  <= SEND;
                        tx_reg <= in_data;
                    end
                end
                SEND: begin
                    cnt <= cnt == LAST_BIT ? '0 : cnt + 1'b1;
                    if (cnt == LAST_BIT) state <= DEPTH > WIDTH ? WAIT : RECV;
                end
                WAIT: begin
                    cnt <= cnt == LAST_WAIT ? '0 : cnt + 1'b1;
                    if (cnt == LAST_WAIT) state <= RECV;
                end
                RECV: begin
                    rx_reg <= rx_nxt;
                    cnt    <= cnt == LAST_BIT ? '0 : cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state     <= DONE;
                        out_data  <= rx_nxt;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    cnt <= '0;
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= CLR;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef SISO_CHECK_EN
    always_ff @(posedge clk) begin
        if (!clear_n)
            err <= 1'b0;
        else if (state == IDLE && in_valid)
            err <= 1'b0;
        else if (state == RECV && cnt == LAST_BIT)
            err <= rx_nxt != tx_reg;
    end
`endif
endmodule

// File: tb/tb_siso_xfer_ctrl.sv
// tb_siso_xfer_ctrl: checks siso_xfer_ctrl against a transaction-level model of the serial loop.
// Instance 0 is the default 32-bit/32-stage MSB-first shape; instance 1 is 8 bits, 13 stages, LSB-first.
module tb_siso_xfer_ctrl;
    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic [1:0]  in_valid = '0;
    logic [1:0]  out_ready = '0;
    logic [31:0] in_data0 = '0;
    logic [7:0]  in_data1 = '0;
    logic [1:0]  in_ready, out_valid, busy, sr_clear, sr_si, sr_so;
    logic [31:0] out_data0;
    logic [7:0]  out_data1;
    logic [31:0] sh0;
    logic [12:0] sh1;
    bit          stuck = 1'b0;
    int          total = 0;
    int          bad = 0;
`ifdef SISO_CHECK_EN
    logic [1:0]  err;
`endif

    always #5 clk = ~clk;

    siso_xfer_ctrl u0 (
        .clk(clk), .clear_n(clear_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data0), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data0), .busy(busy[0]), .sr_clear(sr_clear[0]), .sr_si(sr_si[0]),
        .sr_so(sr_so[0])
`ifdef SISO_CHECK_EN
        , .err(err[0])
`endif
    );

    siso_xfer_ctrl #(.WIDTH(8), .DEPTH(13), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .clear_n(clear_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data1), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data1), .busy(busy[1]), .sr_clear(sr_clear[1]), .sr_si(sr_si[1]),
        .sr_so(sr_so[1])
`ifdef SISO_CHECK_EN
        , .err(err[1])
`endif
    );

    // External shift registers; stage 5 of the 32-stage one can be forced to 1 as a fault
    always @(posedge clk) begin
        sh0 <= sr_clear[0] ? '0 : ({sh0[30:0], sr_si[0]} | (stuck ? 32'h20 : 32'h0));
        sh1 <= sr_clear[1] ? '0 : {sh1[11:0], sr_si[1]};
    end
    assign sr_so = {sh1[12], sh0[31]};

    function automatic int wid(input int k);
        return k == 0 ? 32 : 8;
    endfunction

    function automatic int lat_of(input int k);
        return k == 0 ? 32 + 32 : 13 + 8;
    endfunction

    function automatic logic [31:0] mask(input int k);
        return k == 0 ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    function automatic logic [31:0] od(input int k);
        return k == 0 ? out_data0 : {24'h0, out_data1};
    endfunction

    // Stream position i holds the i-th bit in transmit order
    function automatic logic [31:0] model_stream(input int k, input logic [31:0] w);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < wid(k); i++) s[i] = k == 0 ? w[wid(k) - 1 - i] : w[i];
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic xfer(input int k, input logic [31:0] w, input int stall, input logic [31:0] exp_w,
                        input int exp_lat, input bit pend_en, input logic [31:0] pend, output int waited);
        int n;
        logic [31:0] s;
        logic [31:0] held;
        bit ok;
        if (k == 0) in_data0 = w; else in_data1 = w[7:0];
        in_valid[k] = 1'b1;
        n = 0;
        while (!in_ready[k] && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        waited = n;
        check("accept_timeout", 64'(n >= 300), 64'(0));
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        check("busy_after_accept", 64'({busy[k], in_ready[k]}), 64'(2'b10));
`ifdef SISO_CHECK_EN
        check("err_cleared", 64'(err[k]), 64'(0));
`endif
        s = '0;
        n = 0;
        while (!out_valid[k] && n < 300) begin
            if (n < wid(k)) s[n] = sr_si[k];
            @(posedge clk); #1;
            n++;
        end
        check("stream", 64'(s), 64'(model_stream(k, w)));
        check("latency", 64'(n), 64'(exp_lat));
        check("out_data", 64'(od(k)), 64'(exp_w));
`ifdef SISO_CHECK_EN
        check("err", 64'(err[k]), 64'(exp_w != (w & mask(k))));
`endif
        if (pend_en) begin
            if (k == 0) in_data0 = pend; else in_data1 = pend[7:0];
            in_valid[k] = 1'b1;
        end
        held = od(k);
        ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            ok = ok && out_valid[k] && od(k) == held && !in_ready[k];
        end
        if (stall > 0) check("stall_hold", 64'(ok), 64'(1));
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        check("handshake", 64'({out_valid[k], in_ready[k]}), 64'(2'b01));
    endtask

    typedef struct {
        int          k;
        logic [31:0] w;
        int          stall;
        bit          stuck;
        logic [31:0] exp_w;
        int          exp_lat;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int waited;
        int k;
        bit seen;
        logic [31:0] w;
        vecs[0] = '{0, 32'hA5F0_0F5A, 0, 1'b0, 32'hA5F0_0F5A, 64};
        vecs[1] = '{0, 32'hFFFF_FFFF, 2, 1'b0, 32'hFFFF_FFFF, 64};
        vecs[2] = '{0, 32'h8000_0001, 1, 1'b1, 32'hFFFF_FFFF, 64};
        vecs[3] = '{0, 32'h0000_0000, 0, 1'b0, 32'h0000_0000, 64};
        vecs[4] = '{1, 32'h0000_0003, 0, 1'b0, 32'h0000_0003, 21};
        vecs[5] = '{1, 32'h0000_0080, 3, 1'b0, 32'h0000_0080, 21};

        clear_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", 64'({sr_clear, busy, in_ready, out_valid, sr_si}), 64'(10'b11_11_00_00_00));
        check("rst_out_data", 64'({out_data1, out_data0}), 64'(0));
        clear_n = 1'b1;
        check("clr_hold", 64'(sr_clear), 64'(2'b11));
        @(posedge clk); #1;
        check("idle_after_clr", 64'({sr_clear, in_ready, busy}), 64'(6'b00_11_00));

        // Reset beats an offered word in IDLE
        in_data0 = 32'h5555_AAAA;
        in_valid[0] = 1'b1;
        clear_n = 1'b0;
        @(posedge clk); #1;
        check("rst_beats_accept", 64'({in_ready[0], sr_clear[0], busy[0]}), 64'(3'b011));
        in_valid[0] = 1'b0;
        clear_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_rst2", 64'({in_ready[0], busy[0]}), 64'(2'b10));

        foreach (vecs[i]) begin
            stuck = vecs[i].stuck;
            xfer(vecs[i].k, vecs[i].w, vecs[i].stall, vecs[i].exp_w, vecs[i].exp_lat, 1'b0, 32'h0, waited);
            stuck = 1'b0;
        end

        // A word offered while DONE stalls is accepted on the cycle after the out handshake
        xfer(0, 32'h1234_5678, 10, 32'h1234_5678, 64, 1'b1, 32'hCAFE_F00D, waited);
        xfer(0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 64, 1'b0, 32'h0, waited);
        check("pend_accept_delay", 64'(waited), 64'(0));

        // Abort in the 20th SEND cycle
        in_data0 = 32'hDEAD_BEEF;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (19) begin
            @(posedge clk); #1;
        end
        check("abort_in_send", 64'({busy[0], in_ready[0]}), 64'(2'b10));
        clear_n = 1'b0;
        @(posedge clk); #1;
        check("abort_clr", 64'({sr_clear[0], busy[0], out_valid[0]}), 64'(3'b110));
        clear_n = 1'b1;
        @(posedge clk); #1;
        check("abort_idle", 64'({sr_clear[0], in_ready[0]}), 64'(2'b01));
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            seen = seen || out_valid[0];
        end
        check("abort_no_out", 64'(seen), 64'(0));
        xfer(0, 32'h0000_0001, 0, 32'h0000_0001, 64, 1'b0, 32'h0, waited);

        for (int i = 0; i < 16; i++) begin
            k = int'($urandom_range(0, 1));
            w = $urandom & mask(k);
            xfer(k, w, int'($urandom_range(0, 3)), w, lat_of(k), 1'b0, 32'h0, waited);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
